// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters through valid/ready handshakes.
// A granted request launches its operands onto registered ALU inputs, the ALU settles
// for one cycle, and the captured result/flags are returned tagged with the requester id.
// Optional build macro ALU_ARB_RR_EN: round-robin arbitration between the requesters.
// Without it, req0 has fixed priority over req1.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic             req1_sub,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op_select,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    input  logic             alu_NO,
    input  logic             alu_ZO,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_any_valid;
    logic             w_win;
    logic             w_accept;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic             r_alu_sub;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;

    assign w_any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    // On contention pick the requester that did not win last time; a sole requester always wins
    always_comb begin
        w_win = req1_valid;
        if (req0_valid && req1_valid) begin
            w_win = ~r_last_grant;
        end
    end

    // Remember the latest winner; starting at 1 lets req0 take the first contention
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_win;
        end
    end
`else
    // Fixed priority: req1 is granted only when req0 is not asking
    always_comb begin
        w_win = ~req0_valid & req1_valid;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the grant strobes and response/busy indications
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (reset && w_any_valid) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_win;
                    req1_ready  = w_win;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Launch the winner's operands onto the ALU; they persist until the next grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_alu_sub <= 1'b0;
            r_rsp_id  <= 1'b0;
        end else if (w_accept) begin
            r_alu_a   <= w_win ? req1_a   : req0_a;
            r_alu_b   <= w_win ? req1_b   : req0_b;
            r_alu_op  <= w_win ? req1_op  : req0_op;
            r_alu_sub <= w_win ? req1_sub : req0_sub;
            r_rsp_id  <= w_win;
        end
    end

    // Capture the settled ALU outputs at the end of EXEC and hold them through RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else if (r_state == S_EXEC) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= {alu_cout, alu_overflow, alu_NO, alu_ZO};
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_op_select = r_alu_op;
    assign alu_sub       = r_alu_sub;
    assign rsp_id        = r_rsp_id;
    assign rsp_result    = r_rsp_result;
    assign rsp_flags     = r_rsp_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in ALU, cycle-level reference model of the arbiter,
// scoreboard of expected responses and an independent response monitor.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_sub;
    logic        req1_valid, req1_ready, req1_sub;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op_select;
    logic        alu_sub, alu_cout, alu_overflow, alu_NO, alu_ZO;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;

    always #5 clk = ~clk;

    // Pending request held by each requester until it is accepted
    logic        p_valid [2];
    logic [15:0] p_a     [2];
    logic [15:0] p_b     [2];
    logic [2:0]  p_op    [2];
    logic        p_sub   [2];

    assign req0_valid = p_valid[0];
    assign req0_a     = p_a[0];
    assign req0_b     = p_b[0];
    assign req0_op    = p_op[0];
    assign req0_sub   = p_sub[0];
    assign req1_valid = p_valid[1];
    assign req1_a     = p_a[1];
    assign req1_b     = p_b[1];
    assign req1_op    = p_op[1];
    assign req1_sub   = p_sub[1];

    // Stand-in ALU: returns {cout, overflow, NO, ZO, result}
    function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input logic sub);
        logic [16:0] s;
        logic [15:0] bb;
        logic [15:0] r;
        logic        c;
        logic        v;
        bb = sub ? ~b : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
                r = s[15:0];
                c = s[16];
                v = (a[15] == bb[15]) && (r[15] != a[15]);
            end
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~a;
            default: r = b;
        endcase
        return {c, v, r[15], (r == 16'd0), r};
    endfunction

    // ALU output is scrambled while a response is on offer, so the held response must not follow it
    logic [19:0] noise;
    logic [19:0] w_alu;
    assign w_alu = alu_f(alu_a, alu_b, alu_op_select, alu_sub) ^ (rsp_valid ? noise : 20'd0);
    assign alu_result = w_alu[15:0];
    assign {alu_cout, alu_overflow, alu_NO, alu_ZO} = w_alu[19:16];

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_sub(req1_sub),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_select(alu_op_select), .alu_sub(alu_sub),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .alu_NO(alu_NO), .alu_ZO(alu_ZO),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [20:0] sb[$];          // expected {id, flags, result}
    logic [20:0] last_hs = '0;   // last response taken by the consumer
    int          g_log[$];
    bit          g_en = 0;

    // Reference model state
    bit          m_inflight = 0;
    int          m_age = 0;
    logic        m_last = 1'b1;
    bit          m_chk_rst = 0;
    logic [15:0] m_alu_a = '0, m_alu_b = '0;
    logic [2:0]  m_alu_op = '0;
    logic        m_alu_sub = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: every offered response must match the oldest expected one
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: got %0h expected no response",
                         {rsp_id, rsp_flags, rsp_result});
            end else begin
                if ({rsp_id, rsp_flags, rsp_result} !== sb[0]) begin
                    n_errors++;
                    $display("FAIL rsp_payload: got %0h expected %0h",
                             {rsp_id, rsp_flags, rsp_result}, sb[0]);
                end
                if (rsp_ready && reset) begin
                    last_hs = {rsp_id, rsp_flags, rsp_result};
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic sub);
        p_a[n]     = a;
        p_b[n]     = b;
        p_op[n]    = op;
        p_sub[n]   = sub;
        p_valid[n] = 1'b1;
    endtask

    task automatic issue_rand(input int n);
        issue(n, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    // One clock cycle: check the model's view of this cycle, then advance it across the edge
    task automatic step();
        logic acc, win, done, rst_now;
        @(negedge clk);
        rst_now = !reset;
        acc     = 1'b0;
        win     = 1'b0;
        done    = 1'b0;
        if (m_chk_rst) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_flags", rsp_flags, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_op", alu_op_select, 0);
            chk("rst_alu_sub", alu_sub, 0);
            m_chk_rst = 0;
        end
        if (rst_now) begin
            chk("ready0_in_reset", req0_ready, 0);
            chk("ready1_in_reset", req1_ready, 0);
        end else begin
            chk("alu_a", alu_a, m_alu_a);
            chk("alu_b", alu_b, m_alu_b);
            chk("alu_op", alu_op_select, m_alu_op);
            chk("alu_sub", alu_sub, m_alu_sub);
            if (!m_inflight) begin
                chk("busy_idle", busy, 0);
                chk("rsp_valid_idle", rsp_valid, 0);
                if (p_valid[0] || p_valid[1]) begin
                    acc = 1'b1;
`ifdef ALU_ARB_RR_EN
                    win = (p_valid[0] && p_valid[1]) ? !m_last : p_valid[1];
`else
                    win = !p_valid[0];
`endif
                    sb.push_back({win, alu_f(p_a[win], p_b[win], p_op[win], p_sub[win])});
                    if (g_en) g_log.push_back(int'(win));
                end
                chk("req0_ready", req0_ready, acc && !win);
                chk("req1_ready", req1_ready, acc && win);
            end else begin
                chk("busy_active", busy, 1);
                chk("req0_ready_busy", req0_ready, 0);
                chk("req1_ready_busy", req1_ready, 0);
                chk("rsp_valid_timing", rsp_valid, m_age >= 1);
                done = (m_age >= 1) && rsp_ready;
            end
        end
        @(posedge clk);
        #1;
        if (rst_now) begin
            m_inflight = 0;
            m_last     = 1'b1;
            m_alu_a    = '0;
            m_alu_b    = '0;
            m_alu_op   = '0;
            m_alu_sub  = 1'b0;
            m_chk_rst  = 1;
            sb.delete();
        end else if (acc) begin
            m_inflight = 1;
            m_age      = 0;
            m_last     = win;
            m_alu_a    = p_a[win];
            m_alu_b    = p_b[win];
            m_alu_op   = p_op[win];
            m_alu_sub  = p_sub[win];
            p_valid[win] = 1'b0;
        end else if (done) begin
            m_inflight = 0;
        end else if (m_inflight) begin
            m_age++;
        end
        noise = 20'($urandom);
    endtask

    task automatic wait_idle();
        int budget = 60;
        while ((m_inflight || p_valid[0] || p_valid[1]) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle_timeout: got busy expected idle within 60 cycles");
        end
    endtask

    initial begin
        noise     = '0;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            p_valid[n] = 1'b0;
            p_a[n]     = '0;
            p_b[n]     = '0;
            p_op[n]    = '0;
            p_sub[n]   = 1'b0;
        end
        repeat (2) step();
        reset = 1'b1;
        step();

        // Simple add from req0
        issue(0, 16'h0003, 16'h0004, 3'b000, 1'b0);
        wait_idle();
        chk("t1_response", last_hs, {1'b0, 4'b0000, 16'h0007});

        // Signed overflow from req1
        issue(1, 16'h7FFF, 16'h0001, 3'b000, 1'b0);
        wait_idle();
        chk("t2_response", last_hs, {1'b1, 4'b0110, 16'h8000});

        // Both requesters asking continuously
        g_en = 1;
        for (int c = 0; c < 20; c++) begin
            if (!p_valid[0]) issue_rand(0);
            if (!p_valid[1]) issue_rand(1);
            step();
        end
        g_en = 0;
        chk("t3_enough_grants", g_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < g_log.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            chk("t3_grant_order", g_log[i], i % 2);
`else
            chk("t3_grant_order", g_log[i], 0);
`endif
        end
        wait_idle();

        // Consumer stalls for 5 cycles while req1 waits
        rsp_ready = 1'b0;
        issue(0, 16'h1234, 16'h0F0F, 3'd3, 1'b0);
        step();
        step();
        issue(1, 16'h00FF, 16'h0F00, 3'd2, 1'b0);
        repeat (5) step();
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while an op is executing: it is dropped, the next request is served
        issue(0, 16'hAAAA, 16'h5555, 3'd0, 1'b0);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        issue(1, 16'h0010, 16'h0001, 3'd0, 1'b1);
        wait_idle();
        chk("t5_after_reset", last_hs, {1'b1, alu_f(16'h0010, 16'h0001, 3'd0, 1'b1)});

        // Subtract to zero
        issue(0, 16'h0005, 16'h0005, 3'b000, 1'b1);
        wait_idle();
        chk("t6_response", last_hs, {1'b0, 4'b1001, 16'h0000});

        // Random traffic with random consumer back-pressure
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_valid[n] && $urandom_range(0, 2) == 0) issue_rand(n);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready = 1'b1;
        wait_idle();
        step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
